// File: rtl/div_ctrl_if.sv
// Request/response and divider-core signal bundle for div_ctrl.
// The master side is the execute-stage M-unit plus the iterative core;
// the slave side is div_ctrl itself.
interface div_ctrl_if #(
  parameter int WIDTH = 32
);

  // Request from the M-unit decode
  logic             i_valid;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_rs1;
  logic [WIDTH-1:0] i_rs2;
  logic             i_flush;

  // Writeback towards the pipeline
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_result;

  // Unsigned iterative divider core
  logic             o_div_start;
  logic [WIDTH-1:0] o_div_a;
  logic [WIDTH-1:0] o_div_b;
  logic [WIDTH-1:0] i_div_res;
  logic [WIDTH-1:0] i_div_rem;
  logic             i_div_ok;

  modport master (
    output i_valid, i_op, i_rs1, i_rs2, i_flush,
    output i_div_res, i_div_rem, i_div_ok,
    input  o_busy, o_done, o_result,
    input  o_div_start, o_div_a, o_div_b
  );

  modport slave (
    input  i_valid, i_op, i_rs1, i_rs2, i_flush,
    input  i_div_res, i_div_rem, i_div_ok,
    output o_busy, o_done, o_result,
    output o_div_start, o_div_a, o_div_b
  );

endinterface

// File: rtl/div_ctrl.sv
// Sequencing and sign-handling front end for the unsigned iterative divider.
// Resolves divide-by-zero and signed overflow locally, otherwise hands the
// core operand magnitudes, waits for it, and sign-corrects the answer into a
// single registered writeback value announced by a one-cycle done pulse.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  div_ctrl_if.slave   bus
);

  localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    SPECIAL,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic             isRem_q, isRem_d;
  logic             negRes_q, negRes_d;
  logic             divZero_q, divZero_d;
  logic             ovf_q, ovf_d;
  logic             waitCnt_q, waitCnt_d;
  logic [WIDTH-1:0] rs1_q, rs1_d;
  logic [WIDTH-1:0] divA_q, divA_d;
  logic [WIDTH-1:0] divB_q, divB_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             divStart;

  logic             reqSigned;
  logic             reqNegA;
  logic             reqNegB;
  logic             reqIsRem;
  logic             reqNegRes;
  logic             reqDivZero;
  logic             reqOvf;
  logic [WIDTH-1:0] reqMagA;
  logic [WIDTH-1:0] reqMagB;

  logic [WIDTH-1:0] coreVal;
  logic [WIDTH-1:0] coreResult;
  logic [WIDTH-1:0] specialResult;

  // Decode the incoming request: signedness, operand magnitudes, the sign the
  // final answer must carry, and whether a RISC-V special case applies.
  // The most negative value maps onto itself, which is its correct unsigned
  // magnitude.
  always_comb begin
    reqSigned  = ~bus.i_op[0];
    reqIsRem   = bus.i_op[1];
    reqNegA    = reqSigned & bus.i_rs1[WIDTH-1];
    reqNegB    = reqSigned & bus.i_rs2[WIDTH-1];
    reqMagA    = reqNegA ? (~bus.i_rs1 + 1'b1) : bus.i_rs1;
    reqMagB    = reqNegB ? (~bus.i_rs2 + 1'b1) : bus.i_rs2;
    reqNegRes  = reqIsRem ? reqNegA : (reqNegA ^ reqNegB);
    reqDivZero = (bus.i_rs2 == '0);
    reqOvf     = reqSigned & (bus.i_rs1 == SIGNED_MIN) & (bus.i_rs2 == ALL_ONES);
  end

  // Form both candidate answers from captured state: the sign-corrected core
  // output and the locally resolved special-case value.
  always_comb begin
    coreVal    = isRem_q ? bus.i_div_rem : bus.i_div_res;
    coreResult = negRes_q ? (~coreVal + 1'b1) : coreVal;
    if (divZero_q) begin
      specialResult = isRem_q ? rs1_q : ALL_ONES;
    end else begin
      specialResult = isRem_q ? '0 : SIGNED_MIN;
    end
  end

  // Next-state and datapath update; a flush overrides all sequencing and
  // drops back to IDLE without touching the held result.
  always_comb begin
    state_d   = state_q;
    isRem_d   = isRem_q;
    negRes_d  = negRes_q;
    divZero_d = divZero_q;
    ovf_d     = ovf_q;
    waitCnt_d = waitCnt_q;
    rs1_d     = rs1_q;
    divA_d    = divA_q;
    divB_d    = divB_q;
    result_d  = result_q;
    divStart  = 1'b0;

    if (bus.i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            isRem_d   = reqIsRem;
            negRes_d  = reqNegRes;
            divZero_d = reqDivZero;
            ovf_d     = reqOvf;
            rs1_d     = bus.i_rs1;
            if (reqDivZero || reqOvf) begin
              state_d = SPECIAL;
            end else begin
              divA_d  = reqMagA;
              divB_d  = reqMagB;
              state_d = LOAD;
            end
          end
        end

        SPECIAL: begin
          result_d = specialResult;
          state_d  = DONE;
        end

        LOAD: begin
          // A core abandoned by an earlier flush may still be iterating;
          // only launch once it reports idle.
          if (bus.i_div_ok) begin
            divStart  = 1'b1;
            waitCnt_d = 1'b0;
            state_d   = WAIT_BUSY;
          end
        end

        WAIT_BUSY: begin
          // A core that finishes instantly never drops i_div_ok, so give up
          // waiting for the busy indication after two cycles.
          if (!bus.i_div_ok || waitCnt_q) begin
            state_d = WAIT_DONE;
          end else begin
            waitCnt_d = 1'b1;
          end
        end

        WAIT_DONE: begin
          if (bus.i_div_ok) begin
            result_d = coreResult;
            state_d  = DONE;
          end
        end

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      isRem_q   <= 1'b0;
      negRes_q  <= 1'b0;
      divZero_q <= 1'b0;
      ovf_q     <= 1'b0;
      waitCnt_q <= 1'b0;
      rs1_q     <= '0;
      divA_q    <= '0;
      divB_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      isRem_q   <= isRem_d;
      negRes_q  <= negRes_d;
      divZero_q <= divZero_d;
      ovf_q     <= ovf_d;
      waitCnt_q <= waitCnt_d;
      rs1_q     <= rs1_d;
      divA_q    <= divA_d;
      divB_q    <= divB_d;
      result_q  <= result_d;
    end
  end

  assign bus.o_busy      = (state_q != IDLE);
  assign bus.o_done      = (state_q == DONE);
  assign bus.o_result    = result_q;
  assign bus.o_div_start = divStart;
  assign bus.o_div_a     = divA_q;
  assign bus.o_div_b     = divB_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural iterative-core model and an
// expected-result scoreboard filled at request time and drained on o_done.
module tb_div_ctrl;

  localparam int WIDTH = 32;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  div_ctrl_if #(.WIDTH(WIDTH)) bus ();

  div_ctrl #(.WIDTH(WIDTH)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int assertCount = 0;
  int failCount   = 0;
  int doneCount   = 0;
  int startCount  = 0;
  int doneBase    = 0;
  int startBase   = 0;
  int coreDelay   = 4;
  int coreCnt     = 0;
  logic [31:0] pendRes;
  logic [31:0] pendRem;
  logic [31:0] lastExp = '0;
  logic [31:0] expQ[$];

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Behavioural unsigned divider: latches operands on start, drops i_div_ok
  // for coreDelay cycles (never when coreDelay is 0), and shows junk while busy.
  always @(posedge i_clk) begin
    if (!i_rst) begin
      bus.i_div_ok  <= 1'b1;
      bus.i_div_res <= '0;
      bus.i_div_rem <= '0;
      coreCnt       <= 0;
    end else if (bus.o_div_start) begin
      if (coreDelay == 0) begin
        bus.i_div_res <= (bus.o_div_b == 0) ? 32'hFFFF_FFFF : bus.o_div_a / bus.o_div_b;
        bus.i_div_rem <= (bus.o_div_b == 0) ? bus.o_div_a : bus.o_div_a % bus.o_div_b;
        bus.i_div_ok  <= 1'b1;
      end else begin
        pendRes       <= (bus.o_div_b == 0) ? 32'hFFFF_FFFF : bus.o_div_a / bus.o_div_b;
        pendRem       <= (bus.o_div_b == 0) ? bus.o_div_a : bus.o_div_a % bus.o_div_b;
        bus.i_div_res <= 32'hDEAD_BEEF;
        bus.i_div_rem <= 32'hBADC_0FFE;
        bus.i_div_ok  <= 1'b0;
        coreCnt       <= coreDelay - 1;
      end
    end else if (!bus.i_div_ok) begin
      if (coreCnt == 0) begin
        bus.i_div_ok  <= 1'b1;
        bus.i_div_res <= pendRes;
        bus.i_div_rem <= pendRem;
      end else begin
        coreCnt <= coreCnt - 1;
      end
    end
  end

  // Pulse monitor: counts done and start cycles, and insists the core is idle
  // whenever a start is issued.
  always @(negedge i_clk) begin
    if (bus.o_done === 1'b1) doneCount++;
    if (bus.o_div_start === 1'b1) begin
      startCount++;
      checkValue("start_core_idle", {31'b0, bus.i_div_ok}, 32'h1);
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp);
    @(negedge i_clk);
    bus.i_valid = 1'b1;
    bus.i_op    = op;
    bus.i_rs1   = a;
    bus.i_rs2   = b;
    expQ.push_back(exp);
    @(posedge i_clk);
    #1;
    doneBase    = doneCount;
    startBase   = startCount;
    bus.i_valid = 1'b0;
    bus.i_op    = ~op;
    bus.i_rs1   = $urandom;
    bus.i_rs2   = '0;
  endtask

  task automatic checkOutput(input string tag, input int expLat, input int expStarts);
    int lat = 0;
    logic [31:0] expVal;
    while (lat < 300) begin
      @(negedge i_clk);
      lat++;
      if (bus.o_done === 1'b1) break;
    end
    checkValue({tag, "_done_seen"}, {31'b0, bus.o_done}, 32'h1);
    if (expLat >= 0) checkValue({tag, "_latency"}, lat, expLat);
    expVal = (expQ.size() != 0) ? expQ.pop_front() : 32'hXXXX_XXXX;
    checkValue({tag, "_result"}, bus.o_result, expVal);
    lastExp = expVal;
    @(posedge i_clk);
    #1;
    checkValue({tag, "_done_single"}, {31'b0, bus.o_done}, 32'h0);
    checkValue({tag, "_idle_after"}, {31'b0, bus.o_busy}, 32'h0);
    checkValue({tag, "_result_held"}, bus.o_result, expVal);
    checkValue({tag, "_done_count"}, doneCount - doneBase, 1);
    checkValue({tag, "_start_count"}, startCount - startBase, expStarts);
  endtask

  task automatic checkAllZero(input string tag);
    checkValue({tag, "_busy"}, {31'b0, bus.o_busy}, 32'h0);
    checkValue({tag, "_done"}, {31'b0, bus.o_done}, 32'h0);
    checkValue({tag, "_start"}, {31'b0, bus.o_div_start}, 32'h0);
    checkValue({tag, "_result"}, bus.o_result, 32'h0);
    checkValue({tag, "_div_a"}, bus.o_div_a, 32'h0);
    checkValue({tag, "_div_b"}, bus.o_div_b, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_op    = OP_DIV;
    bus.i_rs1   = '0;
    bus.i_rs2   = '0;
    bus.i_flush = 1'b0;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checkAllZero("reset");
    i_rst = 1'b1;

    coreDelay = 4;
    applyStimulus(OP_DIV, 32'd20, 32'd3, 32'd6);
    checkOutput("div_20_3", 7, 1);
    applyStimulus(OP_REM, 32'd20, 32'd3, 32'd2);
    checkOutput("rem_20_3", 7, 1);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFE);
    checkOutput("div_m7_3", 7, 1);
    applyStimulus(OP_REM, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF);
    checkOutput("rem_m7_3", 7, 1);
    applyStimulus(OP_REM, 32'd7, 32'hFFFF_FFFD, 32'd1);
    checkOutput("rem_7_m3", 7, 1);
    coreDelay = 2;
    applyStimulus(OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);
    checkOutput("divu_max_2", 5, 1);

    applyStimulus(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    checkOutput("div_5_0", 2, 0);
    applyStimulus(OP_REMU, 32'd5, 32'd0, 32'd5);
    checkOutput("remu_5_0", 2, 0);
    applyStimulus(OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    checkOutput("rem_m5_0", 2, 0);

    coreDelay = 4;
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    checkOutput("div_ovf", 2, 0);
    applyStimulus(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    checkOutput("rem_ovf", 2, 0);
    applyStimulus(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    checkOutput("divu_min_max", 7, 1);

    coreDelay = 0;
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd14);
    checkOutput("divu_instant", 5, 1);

    // Flush while waiting on a slow core, then reuse with the core still busy
    coreDelay = 8;
    applyStimulus(OP_DIV, 32'd100, 32'd7, 32'd14);
    repeat (3) @(negedge i_clk);
    checkValue("flush_pre_busy", {31'b0, bus.o_busy}, 32'h1);
    bus.i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_flush = 1'b0;
    void'(expQ.pop_front());
    checkValue("flush_busy", {31'b0, bus.o_busy}, 32'h0);
    checkValue("flush_result_held", bus.o_result, lastExp);
    repeat (4) @(negedge i_clk);
    checkValue("flush_no_done", doneCount - doneBase, 0);
    coreDelay = 3;
    applyStimulus(OP_DIV, 32'd9, 32'd4, 32'd2);
    checkOutput("div_9_4_after_flush", -1, 1);

    // Flush together with a request in IDLE drops the request
    @(negedge i_clk);
    doneBase    = doneCount;
    startBase   = startCount;
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_op    = OP_DIV;
    bus.i_rs1   = 32'd20;
    bus.i_rs2   = 32'd3;
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    checkValue("flush_idle_busy", {31'b0, bus.o_busy}, 32'h0);
    repeat (4) @(negedge i_clk);
    checkValue("flush_idle_no_start", startCount - startBase, 0);
    checkValue("flush_idle_no_done", doneCount - doneBase, 0);

    // Reset in the middle of an operation
    coreDelay = 6;
    applyStimulus(OP_DIV, 32'd50, 32'd5, 32'd10);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    checkAllZero("midop_reset");
    @(negedge i_clk);
    i_rst = 1'b1;
    void'(expQ.pop_front());
    repeat (3) @(negedge i_clk);
    checkValue("midop_reset_no_done", doneCount - doneBase, 0);
    coreDelay = 3;
    applyStimulus(OP_REMU, 32'd10, 32'd4, 32'd2);
    checkOutput("remu_10_4_after_reset", 6, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing and sign-handling front end for the M-extension unsigned iterative divider core. Sits between the execute-stage M-unit decode and the core.
- Accepts a DIV/DIVU/REM/REMU request and resolves the RISC-V special cases (divide-by-zero, signed overflow) without using the core.
- Otherwise it feeds the core magnitudes, waits for completion, sign-corrects the result, and returns one 32-bit writeback value with a single-cycle done pulse.

Parameters:
- WIDTH, 32, operand/result width; only 32 is required to be supported.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-low
- i_valid  in  1  request strobe; sampled only in IDLE
- i_op  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (funct3[1:0])
- i_rs1  in  WIDTH  dividend
- i_rs2  in  WIDTH  divisor
- i_flush  in  1  abort in-flight op (pipeline kill)
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse; o_result valid in that cycle
- o_result  out  WIDTH  final quotient or remainder, held until the next o_done
- o_div_start  out  1  one-cycle load strobe to the core
- o_div_a  out  WIDTH  unsigned dividend magnitude to the core
- o_div_b  out  WIDTH  unsigned divisor magnitude to the core
- i_div_res  in  WIDTH  core quotient
- i_div_rem  in  WIDTH  core remainder
- i_div_ok  in  1  core idle/finished flag; low while iterating

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - State is IDLE.
  - o_busy=0, o_done=0, o_div_start=0, o_result=0, o_div_a=0, o_div_b=0.
  - Internal flags are cleared.
  - Reset mid-operation discards the operation with no o_done.
- Sign decode: signed = (i_op[0]==0).
  - neg_a = signed & rs1[31]; neg_b = signed & rs2[31].
  - |x| is the two's complement when neg, else x. |0x80000000| = 0x80000000 unsigned.
- Quotient sign = neg_a ^ neg_b. Remainder sign = neg_a.
- op, rs1, neg flags and the special-case flags are captured on acceptance. The inputs are not looked at again.
- FSM states: IDLE, SPECIAL, LOAD, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE: if i_valid, accept the request.
  - If rs2==0, or signed & rs1==0x80000000 & rs2==0xFFFFFFFF, go to SPECIAL.
  - Otherwise latch magnitudes into o_div_a/o_div_b and go to LOAD.
- SPECIAL: compute the result, go to DONE.
  - Divide-by-zero: quotient=0xFFFFFFFF (DIV and DIVU); remainder=rs1 unmodified.
  - Overflow: quotient=0x80000000, remainder=0.
- LOAD: o_div_start=1 for exactly this cycle, operands stable. Go to WAIT_BUSY.
- WAIT_BUSY: wait until i_div_ok=0, then go to WAIT_DONE. If i_div_ok is still 1 after 2 cycles in this state, go to WAIT_DONE anyway; this is the guard for a core that finished instantly.
- WAIT_DONE: when i_div_ok=1, select the value and go to DONE.
  - REM ops use i_div_rem; DIV ops use i_div_res.
  - Negate the value if its sign flag is set.
  - Register the result into o_result.
- DONE: o_done=1 for one cycle, then IDLE. A new i_valid is accepted in the cycle after DONE, not during it.
- Latency from the accept edge to o_done high:
  - Special cases: 2 cycles.
  - Normal: 3 cycles plus the core busy duration.
- i_flush: in any non-IDLE state, go to IDLE on the next edge.
  - No o_done; o_result is unchanged.
  - If the flush lands during WAIT_*, the core is left running. The next LOAD is only issued once i_div_ok=1, so LOAD stalls while i_div_ok=0.
  - i_flush together with i_valid in IDLE: the request is ignored.
- Priority: reset > flush > FSM.
- i_op and operand changes after acceptance have no effect.

Test Plan:
- DIV 20/3 -> o_result=6. REM 20/3 -> 2. Exactly one o_done pulse per op; o_div_start high exactly 1 cycle per op.
- DIV -7/3 -> 0xFFFFFFFE (-2). REM -7/3 -> 0xFFFFFFFF (-1). REM 7/-3 -> 1. DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
- DIV 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. REM -5/0 -> 0xFFFFFFFB. Each has o_done 2 cycles after accept and o_div_start never asserted.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0. DIVU of the same -> 0 via the core path.
- Assert i_flush during WAIT_DONE -> no o_done, o_busy low next cycle. A following DIV 9/4 returns 2 with the correct value.
- Drop i_rst to 0 mid-operation -> all outputs 0 next cycle. After release, REMU 10/4 -> 2.
